button_conditioner: RTL

Input-side companion to the board display path. It turns raw, asynchronous, bouncy board inputs (btnC/U/L/D, optionally switches) into clean, clock-synchronous levels and single-cycle press, release and auto-repeat pulses. These feed the CPU io_in path and single-step control. It sits between the top-level pins and the CPU, on the fast board clock.

---
 rtl/board_io_pkg.sv | 14 +
 rtl/debounce_channel.sv | 134 +++++++++++++
 rtl/button_conditioner.sv | 37 +++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared board I/O timing constants and the ms-to-cycles conversion used
// to derive default debounce and auto-repeat parameters.
package board_io_pkg;

   localparam int CLK_HZ           = 32'd100_000_000;
   localparam int DEBOUNCE_MS      = 32'd10;
   localparam int REPEAT_DELAY_MS  = 32'd500;
   localparam int REPEAT_PERIOD_MS = 32'd100;

   function automatic int ms_to_cycles(input int ms);
      return (CLK_HZ / 32'd1000) * ms;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce counter, auto-repeat FSM
// and registered press/release/repeat pulses.
module debounce_channel
   import board_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
   parameter int REPEAT_DELAY    = ms_to_cycles(REPEAT_DELAY_MS),
   parameter int REPEAT_PERIOD   = ms_to_cycles(REPEAT_PERIOD_MS)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic repeat_pulse
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      REPEATING = 2'd2
   } rpt_state_e;

   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW      = $clog2(REP_MAX + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic          sync_meta_q, sync_q;
   logic          level_q, level_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   rpt_state_e    state_q, state_d;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          repeat_q, repeat_d;
   logic          rise_s, fall_s;

   // Level toggles on the edge where the stable-mismatch count would hit DEBOUNCE_CYCLES.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = '0;
      if (sync_q != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d = ~level_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end else begin
         deb_cnt_d = '0;
      end
   end

   assign rise_s = level_d & ~level_q;
   assign fall_s = ~level_d & level_q;

   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      press_d   = rise_s;
      release_d = fall_s;
      if (fall_s) begin
         state_d   = IDLE;
         rpt_cnt_d = '0;
      end else if (rise_s) begin
         state_d   = HELD;
         rpt_cnt_d = '0;
         repeat_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               rpt_cnt_d = '0;
            end
            HELD: begin
               if (REPEAT_DELAY == 0) begin
                  rpt_cnt_d = '0;
               end else if (rpt_cnt_q == DLY_LAST) begin
                  state_d   = REPEATING;
                  rpt_cnt_d = '0;
                  repeat_d  = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
            REPEATING: begin
               if (rpt_cnt_q == PER_LAST) begin
                  rpt_cnt_d = '0;
                  repeat_d  = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = IDLE;
               rpt_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta_q <= 1'b0;
         sync_q      <= 1'b0;
         level_q     <= 1'b0;
         deb_cnt_q   <= '0;
         state_q     <= IDLE;
         rpt_cnt_q   <= '0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         sync_meta_q <= raw_in;
         sync_q      <= sync_meta_q;
         level_q     <= level_d;
         deb_cnt_q   <= deb_cnt_d;
         state_q     <= state_d;
         rpt_cnt_q   <= rpt_cnt_d;
         press_q     <= press_d;
         release_q   <= release_d;
         repeat_q    <= repeat_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_INPUTS raw board inputs into debounced levels and
// press/release/auto-repeat pulses; one independent channel per input.
module button_conditioner
   import board_io_pkg::*;
#(
   parameter int NUM_INPUTS      = 5,
   parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
   parameter int REPEAT_DELAY    = ms_to_cycles(REPEAT_DELAY_MS),
   parameter int REPEAT_PERIOD   = ms_to_cycles(REPEAT_PERIOD_MS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_INPUTS-1:0] raw_in,
   output logic [NUM_INPUTS-1:0] level,
   output logic [NUM_INPUTS-1:0] press,
   // release/repeat are language keywords, hence the _pulse suffix
   output logic [NUM_INPUTS-1:0] release_pulse,
   output logic [NUM_INPUTS-1:0] repeat_pulse
);

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .raw_in        (raw_in[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule
